// File: rtl/fnd_pkg.sv
// ----------------------------------------------------------------------------
// fnd_pkg
// Shared constants for the 7-segment scan driver: active-low segment codes,
// the hex font table and the common-enable polarity helper.
// Segment bit order everywhere: bit7 = dp, bit6 = g ... bit0 = a, 0 = lit.
// ----------------------------------------------------------------------------
package fnd_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] seg_t;

    localparam seg_t FONT_BLANK   = 8'hff;
    localparam seg_t FONT_DP_MASK = 8'h7f;

    // Entry [n] is the glyph for hex digit n (entry 0 is the rightmost literal).
    localparam logic [15:0][7:0] FONT_TABLE = {
        8'h8e, 8'h86, 8'ha1, 8'hc6,   // F E d C
        8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
        8'hf8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hb0, 8'ha4, 8'hf9, 8'hc0    // 3 2 1 0
    };

    // Convert an active-high one-hot select into pin levels.
    // Up to 8 commons are supported; callers slice off the unused upper bits.
    function automatic logic [7:0] com_drive(input logic [7:0] sel, input logic act_lo);
        return act_lo ? ~sel : sel;
    endfunction

endpackage

// File: rtl/fnd_font_rom.sv
// ----------------------------------------------------------------------------
// fnd_font_rom
// Combinational hex-to-7-segment decoder (active-low, dp bit left dark).
// Ports:
//   i_nib   in  4  hex nibble
//   o_font  out 8  segment pattern, bit7=dp (always 1 here), 0 = lit
// ----------------------------------------------------------------------------
module fnd_font_rom
    import fnd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_font
);

    assign o_font = FONT_TABLE[i_nib];

endmodule

// File: rtl/fnd_scan_driver.sv
// ----------------------------------------------------------------------------
// fnd_scan_driver
// Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
// A pending buffer captures new data on i_load; the active snapshot is only
// refreshed at frame end, so a frame is never torn. Each digit slot opens
// with DEAD_CYC cycles of all commons off to avoid ghosting.
//
// Parameters:
//   DIGITS      digits scanned (1..8)
//   SLOT_CYC    clock cycles per digit slot, dead time included
//   DEAD_CYC    dead cycles at slot start (0 allowed)
//   COM_ACT_LO  1: o_com active-low, 0: active-high
// Ports:
//   i_clk      in  1         system clock
//   i_reset_n  in  1         synchronous reset, active-low
//   i_value    in  4*DIGITS  hex nibble per digit, digit 0 = [3:0] (rightmost)
//   i_dp       in  DIGITS    decimal point per digit
//   i_blank    in  DIGITS    force digit dark
//   i_load     in  1         capture strobe into the pending buffer
//   o_font     out 8         segment bus, bit7=dp, 0 = lit
//   o_com      out DIGITS    one-hot digit common enables
//   o_frame    out 1         pulse aligned with the outputs of the last frame cycle
// Build option:
//   FND_LZ_SUPPRESS_EN  blank leading zeros of the active snapshot
//                       (digit 0 always shown)
// ----------------------------------------------------------------------------
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SLOT_CYC   = 100000,
    parameter int DEAD_CYC   = 2,
    parameter int COM_ACT_LO = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [DIGITS-1:0]     i_blank,
    input  logic                  i_load,
    output logic [7:0]            o_font,
    output logic [DIGITS-1:0]     o_com,
    output logic                  o_frame
);

    localparam int CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYC - 1);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIGITS - 1);

    // scan position
    logic [CNT_W-1:0]          r_slot_cnt;
    logic [DIG_W-1:0]          r_dig_idx;

    // double buffer
    logic [DIGITS-1:0][3:0]    r_pend_val;
    logic [DIGITS-1:0]         r_pend_dp;
    logic [DIGITS-1:0]         r_pend_blank;
    logic                      r_pend_vld;
    logic [DIGITS-1:0][3:0]    r_act_val;
    logic [DIGITS-1:0]         r_act_dp;
    logic [DIGITS-1:0]         r_act_blank;

    logic                      w_slot_end;
    logic                      w_frame_end;
    logic                      w_dead;
    logic [3:0]                w_nib;
    logic                      w_dp;
    logic                      w_blank;
    logic [DIGITS-1:0]         w_lz;
    logic [7:0]                w_font_raw;
    logic [7:0]                w_font;
    logic [DIGITS-1:0]         w_sel;
    logic [7:0]                w_com_on8;
    logic [7:0]                w_com_off8;

    assign w_slot_end  = (r_slot_cnt == SLOT_LAST);
    assign w_frame_end = w_slot_end && (r_dig_idx == DIG_LAST);

    generate
        if (DEAD_CYC == 0) begin : g_no_dead
            assign w_dead = 1'b0;
        end else begin : g_dead
            assign w_dead = (r_slot_cnt < CNT_W'(DEAD_CYC));
        end
    endgenerate

`ifdef FND_LZ_SUPPRESS_EN
    // Walk from the leftmost digit; stay in "leading" mode while digits are
    // plain zeros with no dp. Digit 0 is outside the walk so "0" still shows.
    logic w_lead;
    always_comb begin
        w_lz   = '0;
        w_lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (r_act_val[i] != 4'h0 || r_act_dp[i])
                w_lead = 1'b0;
            w_lz[i] = w_lead;
        end
    end
`else
    assign w_lz = '0;
`endif

    assign w_nib   = r_act_val[r_dig_idx];
    assign w_dp    = r_act_dp[r_dig_idx];
    assign w_blank = r_act_blank[r_dig_idx] | w_lz[r_dig_idx];

    fnd_font_rom u_font_rom (
        .i_nib  (w_nib),
        .o_font (w_font_raw)
    );

    // blank overrides dp as well
    assign w_font = w_blank ? FONT_BLANK
                  : (w_dp ? (w_font_raw & FONT_DP_MASK) : w_font_raw);

    assign w_sel      = DIGITS'(1) << r_dig_idx;
    assign w_com_on8  = com_drive(8'(w_sel), COM_ACT_LO != 0);
    assign w_com_off8 = com_drive(8'h00,     COM_ACT_LO != 0);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_slot_cnt   <= '0;
            r_dig_idx    <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '1;
            r_pend_vld   <= 1'b0;
            r_act_val    <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '1;
            o_font       <= FONT_BLANK;
            o_com        <= w_com_off8[DIGITS-1:0];
            o_frame      <= 1'b0;
        end else begin
            // scan position
            if (w_slot_end) begin
                r_slot_cnt <= '0;
                r_dig_idx  <= (r_dig_idx == DIG_LAST) ? '0 : r_dig_idx + 1'b1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end

            // Frame-end swap happens before the load check so a load landing
            // on the frame-end cycle is kept pending for the next frame.
            if (w_frame_end) begin
                if (r_pend_vld) begin
                    r_act_val   <= r_pend_val;
                    r_act_dp    <= r_pend_dp;
                    r_act_blank <= r_pend_blank;
                end
                r_pend_vld <= 1'b0;
            end
            if (i_load) begin
                r_pend_val   <= i_value;
                r_pend_dp    <= i_dp;
                r_pend_blank <= i_blank;
                r_pend_vld   <= 1'b1;
            end

            // registered outputs reflect the current scan position
            o_font  <= w_dead ? FONT_BLANK : w_font;
            o_com   <= w_dead ? w_com_off8[DIGITS-1:0] : w_com_on8[DIGITS-1:0];
            o_frame <= w_frame_end;
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
module tb_fnd_scan_driver;

    localparam int DIGITS = 4;
    localparam int SLOT   = 8;
    localparam int DEAD   = 2;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic [15:0] i_value;
    logic [3:0]  i_dp;
    logic [3:0]  i_blank;
    logic        i_load;
    logic [7:0]  o_font;
    logic [3:0]  o_com;
    logic        o_frame;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fnd_scan_driver #(
        .DIGITS(DIGITS), .SLOT_CYC(SLOT), .DEAD_CYC(DEAD), .COM_ACT_LO(1)
    ) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_value(i_value), .i_dp(i_dp),
        .i_blank(i_blank), .i_load(i_load), .o_font(o_font), .o_com(o_com),
        .o_frame(o_frame)
    );

    // ---------------- behavioural model ----------------
    logic [7:0] FT [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};

    int         t;                        // cycles since reset release
    logic [3:0] pv [4];
    logic [3:0] av [4];
    logic [3:0] pdp, pbl, adp, abl;
    logic       pvld;
    logic       m_started = 1'b0;
    logic [7:0] exp_font;
    logic [3:0] exp_com;
    logic       exp_frame;

    function automatic logic [7:0] model_glyph(int d);
        int  top;
        logic sup;
        top = 0;
        for (int i = 3; i >= 1; i--)
            if (top == 0 && (av[i] != 4'h0 || adp[i])) top = i;
`ifdef FND_LZ_SUPPRESS_EN
        sup = (d > top);
`else
        sup = 1'b0;
`endif
        if (abl[d] || sup) return 8'hff;
        return adp[d] ? (FT[av[d]] & 8'h7f) : FT[av[d]];
    endfunction

    always @(posedge clk) begin
        int slot, dig;
        m_started = 1'b1;
        if (!i_reset_n) begin
            t = 0; pvld = 1'b0;
            for (int i = 0; i < 4; i++) begin pv[i] = 4'h0; av[i] = 4'h0; end
            pdp = 4'h0; adp = 4'h0; pbl = 4'hf; abl = 4'hf;
            exp_font = 8'hff; exp_com = 4'hf; exp_frame = 1'b0;
        end else begin
            slot = t % SLOT;
            dig  = (t / SLOT) % DIGITS;
            if (slot < DEAD) begin
                exp_font = 8'hff; exp_com = 4'hf;
            end else begin
                exp_font = model_glyph(dig);
                exp_com  = ~(4'b0001 << dig);
            end
            exp_frame = (slot == SLOT - 1) && (dig == DIGITS - 1);
            if (exp_frame) begin
                if (pvld) begin
                    for (int i = 0; i < 4; i++) av[i] = pv[i];
                    adp = pdp; abl = pbl;
                end
                pvld = 1'b0;
            end
            if (i_load) begin
                for (int i = 0; i < 4; i++) pv[i] = i_value[4*i +: 4];
                pdp = i_dp; pbl = i_blank; pvld = 1'b1;
            end
            t++;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_started) begin
            vectors++;
            if (o_font !== exp_font || o_com !== exp_com || o_frame !== exp_frame) begin
                miscompares++;
                $display("FAIL model t=%0d: font=%h com=%b frame=%b, want font=%h com=%b frame=%b",
                         t, o_font, o_com, o_frame, exp_font, exp_com, exp_frame);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // returns cycles waited until o_frame seen at a negedge
    task automatic wait_frame(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (o_frame === 1'b1) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_frame: no o_frame within 100 cycles");
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        i_value = v; i_dp = dp; i_blank = bl; i_load = 1'b1;
        step(1);
        i_load = 1'b0;
    endtask

    initial begin
        int n;
        i_reset_n = 1'b0; i_value = '0; i_dp = '0; i_blank = '0; i_load = 1'b0;

        // reset state
        step(3);
        chk("rst_font",  o_font, 8'hff);
        chk("rst_com",   {4'h0, o_com}, 8'h0f);
        chk("rst_frame", {7'h0, o_frame}, 8'h00);
        i_reset_n = 1'b1;
        step(3);                                   // digit0, first lit cycle
        chk("first_frame_blank_font", o_font, 8'hff);
        chk("first_frame_com",        {4'h0, o_com}, 8'h0e);

        // basic load
        load(16'h1234, 4'h0, 4'h0);
        wait_frame(n); wait_frame(n);
        step(1);
        chk("dead_font", o_font, 8'hff);
        chk("dead_com",  {4'h0, o_com}, 8'h0f);
        step(2);
        chk("d0_font_4", o_font, 8'h99);
        chk("d0_com",    {4'h0, o_com}, 8'h0e);
        step(24);
        chk("d3_font_1", o_font, 8'hf9);
        chk("d3_com",    {4'h0, o_com}, 8'h07);

        // tearing: load mid-frame, current frame keeps old data
        wait_frame(n);
        step(12);
        load(16'hABCD, 4'h0, 4'h0);
        step(14);                                  // k = 27, digit3
        chk("tear_old_d3", o_font, 8'hf9);
        wait_frame(n);
        chk("frame_tail_cycles", 8'(n), 8'd5);
        step(3);  chk("abcd_d0", o_font, 8'ha1);
        step(8);  chk("abcd_d1", o_font, 8'hc6);
        step(8);  chk("abcd_d2", o_font, 8'h83);
        step(8);  chk("abcd_d3", o_font, 8'h88);
        wait_frame(n);
        wait_frame(n);
        chk("frame_period", 8'(n), 8'd32);

        // dp and blank: digit1 is '6' with dp, digit3 forced dark
        load(16'h0567, 4'b0010, 4'b1000);
        wait_frame(n); wait_frame(n);
        step(11); chk("dp_d1", o_font, 8'h02);
        step(16); chk("blank_d3", o_font, 8'hff);

        // reset during digit2 slot
        wait_frame(n);
        step(20);
        i_reset_n = 1'b0;
        step(1);
        chk("midrst_font",  o_font, 8'hff);
        chk("midrst_com",   {4'h0, o_com}, 8'h0f);
        chk("midrst_frame", {7'h0, o_frame}, 8'h00);
        i_reset_n = 1'b1;
        step(3);
        chk("restart_d0_com",  {4'h0, o_com}, 8'h0e);
        chk("restart_d0_font", o_font, 8'hff);

        // leading zeros
        load(16'h0007, 4'h0, 4'h0);
        wait_frame(n); wait_frame(n);
        step(3);  chk("lz7_d0", o_font, 8'hf8);
`ifdef FND_LZ_SUPPRESS_EN
        step(8);  chk("lz7_d1", o_font, 8'hff);
        step(8);  chk("lz7_d2", o_font, 8'hff);
        step(8);  chk("lz7_d3", o_font, 8'hff);
        load(16'h0000, 4'h0, 4'h0);
        wait_frame(n); wait_frame(n);
        step(3);  chk("lz0_d0", o_font, 8'hc0);
        step(8);  chk("lz0_d1", o_font, 8'hff);
`else
        step(8);  chk("lz7_d1", o_font, 8'hc0);
        step(8);  chk("lz7_d2", o_font, 8'hc0);
        step(8);  chk("lz7_d3", o_font, 8'hc0);
`endif

        // randomized traffic, model checks each cycle
        for (int c = 0; c < 2000; c++) begin
            if (c == 900) i_reset_n = 1'b0;
            if (c == 902) i_reset_n = 1'b1;
            i_load = ($urandom_range(0, 24) == 0);
            if (i_load) begin
                i_value = 16'($urandom);
                if ($urandom_range(0, 2) == 0) i_value = i_value & 16'h000f;
                i_dp    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                i_blank = 4'($urandom) & 4'($urandom);
            end
            step(1);
        end
        i_load = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
